// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants for the rv_pack beat packer
// Purpose: default beat width, beats per word and length-field width used by
//          rv_pack and rv_out_slot.
// Ports:   none (package).
package rv_pkg;
  localparam int RV_WD   = 4;
  localparam int RV_NB   = 4;
  localparam int RV_LENW = 3;
endpackage

// File: rtl/rv_out_slot.sv
// rtl/rv_out_slot.sv - single-entry output holding register for packed words
// Purpose: holds one packed word with its length and valid flag; loads when
//          told to, holds while downstream stalls, drains on handshake.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          load              - capture load_data/load_len (only when slot_free)
//          load_data/len     - word and beat count to capture
//          dataout_rdy       - downstream accept
//          dataout/_len/_val - registered output word, length, valid
//          slot_free         - slot empty or draining this cycle
module rv_out_slot #(
  parameter int dw = 16,
  parameter int lw = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [dw-1:0] load_data,
  input  logic [lw-1:0] load_len,
  input  logic          dataout_rdy,
  output logic [dw-1:0] dataout,
  output logic [lw-1:0] dataout_len,
  output logic          dataout_val,
  output logic          slot_free
);

  assign slot_free = !dataout_val || dataout_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout     <= '0;
      dataout_len <= '0;
      dataout_val <= 1'b0;
    end else if (load) begin
      // A load on the same edge as a drain gives back-to-back words.
      dataout     <= load_data;
      dataout_len <= load_len;
      dataout_val <= 1'b1;
    end else if (dataout_val && dataout_rdy) begin
      dataout_val <= 1'b0;
    end
  end

endmodule

// File: rtl/rv_pack.sv
// rtl/rv_pack.sv - packs nb beats of wd bits into one word, with flush support
// Purpose: accumulates beats LSB-first, emits full words through rv_out_slot,
//          and emits partial words on flush.
// Ports:   clk, rst                    - clock, synchronous active-high reset
//          datain/_val/_rdy            - upstream beat handshake
//          flush                       - request to emit the partial word
//          dataout/_len/_val/_rdy      - downstream word handshake
module rv_pack
  import rv_pkg::*;
#(
  parameter int wd = RV_WD,
  parameter int nb = RV_NB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [wd-1:0]        datain,
  input  logic                 datain_val,
  output logic                 datain_rdy,
  input  logic                 flush,
  output logic [nb*wd-1:0]     dataout,
  output logic [RV_LENW-1:0]   dataout_len,
  output logic                 dataout_val,
  input  logic                 dataout_rdy
);

  localparam int cw = $clog2(nb);
  localparam logic [cw-1:0] last_lane = cw'(nb - 1);

  logic [cw-1:0]      cnt;
  logic [nb*wd-1:0]   acc;
  logic               flush_pend;

  logic               slot_free;
  logic               accept;
  logic               full_load;
  logic               flush_load;
  logic               load;
  logic [nb*wd-1:0]   beat_lane;
  logic [nb*wd-1:0]   load_data;
  logic [RV_LENW-1:0] load_len;

  assign datain_rdy = !flush_pend && (cnt != last_lane || slot_free);

  always_comb begin
    accept     = datain_val && datain_rdy;
    // Lanes at and above cnt are always zero in acc, so OR-ing places the beat.
    beat_lane  = (nb*wd)'(datain) << (int'(cnt) * wd);
    full_load  = accept && (cnt == last_lane);
    // Input is blocked while a flush is pending, so these never coincide.
    flush_load = flush_pend && slot_free && (cnt != '0);
    load       = full_load || flush_load;
    load_data  = full_load ? (acc | beat_lane) : acc;
    load_len   = full_load ? RV_LENW'(nb) : RV_LENW'(cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (load) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        cnt <= cnt + cw'(1);
        acc <= acc | beat_lane;
      end
      // A new flush arriving while one is pending is absorbed by it.
      if (flush_pend) flush_pend <= !slot_free;
      else            flush_pend <= flush;
    end
  end

  rv_out_slot #(
    .dw (nb*wd),
    .lw (RV_LENW)
  ) u_out_slot (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (load_data),
    .load_len    (load_len),
    .dataout_rdy (dataout_rdy),
    .dataout     (dataout),
    .dataout_len (dataout_len),
    .dataout_val (dataout_val),
    .slot_free   (slot_free)
  );

endmodule

// File: tb/tb_rv_pack.sv
// tb/tb_rv_pack.sv - self-checking bench for rv_pack
module tb_rv_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  datain = '0;
  logic        datain_val = 1'b0;
  logic        datain_rdy;
  logic        flush = 1'b0;
  logic [15:0] dataout;
  logic [2:0]  dataout_len;
  logic        dataout_val;
  logic        dataout_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  // Behavioural model: queue of buffered beats plus one held output word.
  logic [3:0]  m_beats[$];
  logic        m_pend = 1'b0;
  logic        m_ov = 1'b0;
  logic [15:0] m_od = '0;
  logic [2:0]  m_ol = '0;

  // Words seen leaving the DUT, for literal checks of directed scenarios.
  logic [15:0] got_d[$];
  logic [2:0]  got_l[$];

  always #5 clk = ~clk;

  rv_pack #(.wd(4), .nb(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .datain      (datain),
    .datain_val  (datain_val),
    .datain_rdy  (datain_rdy),
    .flush       (flush),
    .dataout     (dataout),
    .dataout_len (dataout_len),
    .dataout_val (dataout_val),
    .dataout_rdy (dataout_rdy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack_beats();
    logic [15:0] w = '0;
    for (int i = 0; i < m_beats.size(); i++) w = w | (16'(m_beats[i]) << (4 * i));
    return w;
  endfunction

  // Compare, then advance the model to what the next rising edge must produce.
  always @(negedge clk) begin
    logic sf, m_rdy, acc_b, load;
    logic [15:0] lw;
    logic [2:0]  ll;
    sf    = !m_ov || dataout_rdy;
    m_rdy = !m_pend && (m_beats.size() < 3 || sf);
    chk("datain_rdy", 32'(datain_rdy), 32'(m_rdy));
    chk("dataout_val", 32'(dataout_val), 32'(m_ov));
    if (m_ov) begin
      chk("dataout", 32'(dataout), 32'(m_od));
      chk("dataout_len", 32'(dataout_len), 32'(m_ol));
      if (dataout_rdy && !rst) begin
        got_d.push_back(dataout);
        got_l.push_back(dataout_len);
      end
    end
    if (rst) begin
      m_beats.delete();
      m_pend = 1'b0; m_ov = 1'b0; m_od = '0; m_ol = '0;
    end else begin
      acc_b = datain_val && m_rdy;
      load  = 1'b0; lw = '0; ll = '0;
      if (acc_b) begin
        m_beats.push_back(datain);
        if (m_beats.size() == 4) begin
          load = 1'b1; lw = pack_beats(); ll = 3'd4;
          m_beats.delete();
        end
      end else if (m_pend && sf && m_beats.size() > 0) begin
        load = 1'b1; lw = pack_beats(); ll = 3'(m_beats.size());
        m_beats.delete();
      end
      if (m_pend) m_pend = !sf;
      else        m_pend = flush;
      if (load) begin
        m_ov = 1'b1; m_od = lw; m_ol = ll;
      end else if (m_ov && dataout_rdy) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [3:0] d,
                     input logic f, input logic dr);
    rst = r; datain_val = v; datain = d; flush = f; dataout_rdy = dr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic clear_got();
    got_d.delete(); got_l.delete();
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("reset dataout", 32'(dataout), 32'h0);
    chk("reset len", 32'(dataout_len), 32'h0);
    chk("reset val", 32'(dataout_val), 32'h0);
    chk("reset rdy", 32'(datain_rdy), 32'h1);

    // Four beats back to back give one full word.
    clear_got();
    for (int b = 1; b <= 4; b++) cyc(1'b0, 1'b1, 4'(b), 1'b0, 1'b1);
    chk("full word val", 32'(dataout_val), 32'h1);
    chk("full word data", 32'(dataout), 32'h4321);
    idle(3);
    chk("full word count", 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1) chk("full word len", 32'(got_l[0]), 32'd4);

    // Stalled downstream: 5,6,7 fill the accumulator, 8 is refused.
    clear_got();
    for (int b = 1; b <= 7; b++) cyc(1'b0, 1'b1, 4'(b), 1'b0, 1'b0);
    rst = 1'b0; datain_val = 1'b1; datain = 4'h8; dataout_rdy = 1'b0; #1;
    chk("stall rdy at beat 8", 32'(datain_rdy), 32'h0);
    cyc(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
    chk("stall held data", 32'(dataout), 32'h4321);
    cyc(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
    idle(3);
    chk("stall word count", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("stall word0", 32'(got_d[0]), 32'h4321);
      chk("stall word1", 32'(got_d[1]), 32'h8765);
    end

    // Partial flush, then a flush with nothing buffered.
    clear_got();
    cyc(1'b0, 1'b1, 4'hA, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'hB, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    idle(4);
    chk("flush word count", 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1) begin
      chk("flush word data", 32'(got_d[0]), 32'h00BA);
      chk("flush word len", 32'(got_l[0]), 32'd2);
    end

    // Beat accepted with flush while the slot is stalled.
    clear_got();
    for (int b = 1; b <= 4; b++) cyc(1'b0, 1'b1, 4'(b), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("flush stall rdy", 32'(datain_rdy), 32'h0);
      cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    end
    idle(4);
    chk("flush stall count", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("flush stall data", 32'(got_d[1]), 32'h0003);
      chk("flush stall len", 32'(got_l[1]), 32'd1);
    end

    // Reset mid-word discards the partial beats.
    clear_got();
    cyc(1'b0, 1'b1, 4'h9, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'h9, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
    chk("post rst dataout", 32'(dataout), 32'h0);
    chk("post rst len", 32'(dataout_len), 32'h0);
    chk("post rst val", 32'(dataout_val), 32'h0);
    chk("post rst rdy", 32'(datain_rdy), 32'h1);
    for (int b = 1; b <= 4; b++) cyc(1'b0, 1'b1, 4'(b), 1'b0, 1'b1);
    idle(3);
    chk("rst word count", 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1) chk("rst word data", 32'(got_d[0]), 32'h4321);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0),
          4'($urandom),
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 3) != 0));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_pack.md
RV_PACK -- requirements
Module: rv_pack

Interface
REQ-001 The block SHALL have parameter wd, default 4, giving the width of one input beat in bits.
REQ-002 The block SHALL have parameter nb, default 4, giving the number of beats packed into one output word; only nb=4 is required.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port datain, input, wd bits, the upstream beat.
REQ-006 The block SHALL have port datain_val, input, 1 bit, asserted when datain is valid.
REQ-007 The block SHALL have port datain_rdy, output, 1 bit, asserted when the block will accept a beat this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit, a request to emit the partially filled word.
REQ-009 The block SHALL have port dataout, output, nb*wd bits, the packed word.
REQ-010 The block SHALL have port dataout_len, output, 3 bits, the number of valid beats in dataout (1..4).
REQ-011 The block SHALL have port dataout_val, output, 1 bit, asserted when dataout and dataout_len are valid.
REQ-012 The block SHALL have port dataout_rdy, input, 1 bit, asserted when downstream accepts the word this cycle.

Function
REQ-013 The block SHALL accept a beat on a rising edge where datain_val=1 and datain_rdy=1, and a word SHALL leave on a rising edge where dataout_val=1 and dataout_rdy=1.
REQ-014 The block SHALL define slot_free = !dataout_val || dataout_rdy.
REQ-015 The block SHALL drive datain_rdy = !flush_pend && (cnt<3 || slot_free), combinationally and with no dependence on datain_val.
REQ-016 The block SHALL place beat k of a word (k=0..3, in arrival order) at dataout[k*wd +: wd], so the first beat occupies the LSBs.
REQ-017 The block SHALL keep a beat counter cnt (0..3) and an accumulator holding beats 0..cnt-1.
REQ-018 On an accepted beat with cnt<3, the block SHALL store the beat in lane cnt and increment cnt.
REQ-019 On an accepted beat with cnt=3, the block SHALL load dataout with the accumulator plus the beat in lane 3, set dataout_len=4 and dataout_val=1 on the same edge, and clear cnt and the accumulator to 0.
REQ-020 The latency from acceptance of the 4th beat to dataout_val=1 SHALL be one cycle, and sustained throughput SHALL be one beat per cycle with dataout_rdy held at 1.
REQ-021 While dataout_val=1 and dataout_rdy=0, the block SHALL hold dataout, dataout_len and dataout_val stable.
REQ-022 If a word leaves and no new word is loaded on the same edge, dataout_val SHALL fall to 0; a leave and a load on the same edge SHALL produce back-to-back words.
REQ-023 A flush sampled high SHALL set flush_pend on that edge; a beat accepted on the same edge SHALL be included in the flushed word.
REQ-024 While flush_pend=1 and slot_free=1, the block SHALL clear flush_pend; if cnt>0 it SHALL also load dataout with the accumulator, unused upper lanes zero, dataout_len=cnt, dataout_val=1, and clear cnt.
REQ-025 A flush with cnt=0 SHALL emit nothing.
REQ-026 A flush sampled while flush_pend=1 SHALL be merged with the pending flush.
REQ-027 The block SHALL NOT emit a word with dataout_len=0.

Reset
REQ-028 On rst=1, the block SHALL set dataout=0, dataout_len=0, dataout_val=0, cnt=0, the accumulator to 0 and flush_pend=0, so that datain_rdy=1 in the following cycle.
REQ-029 A reset during a partial word SHALL discard the buffered beats and any held output word without emitting them.
REQ-030 The block SHALL ignore datain_val and flush in any cycle where rst=1.

Structure
REQ-031 The shared package rv_pkg SHALL hold the default width constant RV_WD=4, the beat count RV_NB=4 and the length width RV_LENW=3.
REQ-032 The output holding register SHALL be implemented as one sub-module, rv_out_slot, containing the data, len and val registers and the load/hold/drain logic with a slot_free output.
REQ-033 Packing, counter and flush control SHALL stay in rv_pack.

Verification
REQ-034 With wd=4 and dataout_rdy=1, beats 1,2,3,4 on consecutive cycles SHALL produce dataout=16'h4321, len=4, val=1 for exactly one cycle, one cycle after beat 4 is accepted.
REQ-035 With dataout_rdy=0 and beats 1..8 offered: word 16'h4321 SHALL be held, beats 5,6,7 accepted and datain_rdy=0 at beat 8; raising dataout_rdy SHALL drain 16'h4321 and then produce 16'h8765.
REQ-036 Beats A, B, then a flush pulse SHALL produce dataout=16'h00BA, len=2; a second flush with cnt=0 SHALL produce no word.
REQ-037 Beat 3 accepted in the same cycle as a flush, with downstream stalled, SHALL keep datain_rdy=0 until the stall clears, then emit len=1, dataout=16'h0003.
REQ-038 Beats 9, 9, then rst for one cycle, then beats 1..4 SHALL produce only 16'h4321, and all outputs SHALL be 0 in the cycle after rst.
